// File: rtl/uart_tx_button_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between debounced buttons.
// Requests are latched as pending bits, granted fairly, and handed to the TX core one at a time.
module uart_tx_button_arbiter #(
    parameter int NUM_BTN     = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int ID_W        = $clog2(NUM_BTN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BTN-1:0]        btn_pulse,
    input  logic [NUM_BTN*DATA_W-1:0] btn_data,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [ID_W-1:0]           grant_id,
    output logic [NUM_BTN-1:0]        pending,
    output logic [NUM_BTN-1:0]        overrun,
    output logic                      ack_err,
    output logic                      ctrl_busy
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] ovr_q, ovr_d;
    logic [NUM_BTN-1:0] clr;
    logic               ack_q, ack_d;
    logic               start_q, cbusy_q;
    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    cidx;

    // Search begins one past the last grant so every button gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cidx      = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            cidx = ID_W'((int'(last_q) + k) % NUM_BTN);
            if (!win_found && pend_q[cidx]) begin
                win_found = 1'b1;
                win_idx   = cidx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        ack_d   = ack_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d      = win_idx;
                    last_d       = win_idx;
                    data_d       = btn_data[win_idx*DATA_W +: DATA_W];
                    clr[win_idx] = 1'b1;
                    state_d      = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        ack_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A pulse landing on the cycle its bit is cleared re-arms the request instead of overrunning.
    assign pend_d = (pend_q & ~clr) | btn_pulse;
    assign ovr_d  = ovr_q | (btn_pulse & pend_q & ~clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= ID_W'(NUM_BTN - 1);
            grant_q <= '0;
            data_q  <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
            cbusy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            start_q <= (state_d == START);
            cbusy_q <= (state_d != IDLE);
        end
    end

    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign grant_id  = grant_q;
    assign pending   = pend_q;
    assign overrun   = ovr_q;
    assign ack_err   = ack_q;
    assign ctrl_busy = cbusy_q;
endmodule

// File: tb/tb_uart_tx_button_arbiter.sv
// Bench for uart_tx_button_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level model driven by cycle numbers.
module tb_uart_tx_button_arbiter;
    localparam int NUM_BTN     = 4;
    localparam int DATA_W      = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int ID_W        = $clog2(NUM_BTN);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_BTN-1:0]        btn_pulse;
    logic [NUM_BTN*DATA_W-1:0] btn_data;
    logic                      tx_busy;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic [ID_W-1:0]           grant_id;
    logic [NUM_BTN-1:0]        pending;
    logic [NUM_BTN-1:0]        overrun;
    logic                      ack_err;
    logic                      ctrl_busy;

    uart_tx_button_arbiter #(
        .NUM_BTN(NUM_BTN), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .btn_data(btn_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .grant_id(grant_id), .pending(pending), .overrun(overrun),
        .ack_err(ack_err), .ctrl_busy(ctrl_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: a transaction is active from its grant cycle+1; m_start is its tx_start cycle.
    logic [NUM_BTN-1:0] m_pend, m_ovr;
    logic               m_ackerr;
    int                 m_last, m_grant;
    logic [DATA_W-1:0]  m_data;
    bit                 m_active, m_seen;
    int                 m_start;

    bit tx_dead;
    int tx_len, win_lo, win_hi;
    int gq[$];
    int dq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_ovr = '0; m_ackerr = 1'b0;
        m_last = NUM_BTN - 1; m_grant = 0; m_data = '0;
        m_active = 1'b0; m_seen = 1'b0; m_start = -100;
    endtask

    task automatic model_update(input logic [NUM_BTN-1:0] p, input logic r, input logic busy);
        logic [NUM_BTN-1:0] clr;
        int w;
        if (r) begin
            model_reset();
            return;
        end
        clr = '0;
        w = -1;
        if (!m_active) begin
            for (int k = 1; k <= NUM_BTN; k++) begin
                if (w < 0 && m_pend[(m_last + k) % NUM_BTN]) w = (m_last + k) % NUM_BTN;
            end
            if (w >= 0) begin
                m_grant = w; m_last = w;
                m_data = btn_data[w*DATA_W +: DATA_W];
                clr[w] = 1'b1;
                m_active = 1'b1; m_start = cyc + 1; m_seen = 1'b0;
            end
        end else if (cyc == m_start) begin
            m_seen = 1'b0;
        end else if (!m_seen) begin
            if (busy) m_seen = 1'b1;
            else if (cyc - m_start == ACK_TIMEOUT) begin
                m_ackerr = 1'b1;
                m_active = 1'b0;
            end
        end else if (!busy) begin
            m_active = 1'b0;
        end
        m_ovr  = m_ovr | (p & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | p;
    endtask

    task automatic check_model();
        chk("tx_start",  32'(tx_start),  32'(m_active && m_start == cyc));
        chk("tx_data",   32'(tx_data),   32'(m_data));
        chk("grant_id",  32'(grant_id),  32'(m_grant));
        chk("pending",   32'(pending),   32'(m_pend));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        chk("ack_err",   32'(ack_err),   32'(m_ackerr));
        chk("ctrl_busy", 32'(ctrl_busy), 32'(m_active));
    endtask

    // One cycle: check outputs, run the TX model, drive inputs, advance past the edge.
    task automatic step(input logic [NUM_BTN-1:0] p, input logic r);
        logic busy_now;
        check_model();
        if (tx_start === 1'b1) begin
            gq.push_back(int'(grant_id));
            dq.push_back(int'(tx_data));
        end
        if (m_active && m_start == cyc) begin
            if (tx_dead) begin
                win_lo = 0; win_hi = 0;
            end else begin
                win_lo = cyc + int'($urandom_range(1, 3));
                win_hi = win_lo + tx_len;
            end
        end
        busy_now  = (cyc >= win_lo) && (cyc < win_hi);
        btn_pulse = p;
        rst       = r;
        tx_busy   = busy_now;
        model_update(p, r, busy_now);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int limit);
        int n;
        n = 0;
        while ((m_active || m_pend != '0) && n < limit) begin
            step('0, 1'b0);
            n++;
        end
        chk("idle_ctrl_busy", 32'(ctrl_busy), 32'(0));
        chk("idle_pending", 32'(pending), 32'(0));
    endtask

    task automatic chk_grants(input string tag, input int exp_ids[$]);
        chk({tag, "_count"}, 32'(gq.size()), 32'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < gq.size(); i++)
            chk({tag, "_id"}, 32'(gq[i]), 32'(exp_ids[i]));
    endtask

    task automatic do_reset();
        step('0, 1'b1);
        gq.delete();
        dq.delete();
    endtask

    initial begin
        int s, n;
        rst = 1'b1; btn_pulse = '0; btn_data = '0; tx_busy = 1'b0;
        tx_dead = 1'b0; tx_len = 10; win_lo = 0; win_hi = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_state", 32'({tx_start, tx_data, grant_id, pending, overrun, ack_err, ctrl_busy}), 32'(0));

        // single request on button 1
        btn_data = {8'h13, 8'h12, 8'h41, 8'h10};
        step(4'b0010, 1'b0);
        step('0, 1'b0);
        chk("t1_start", 32'(tx_start), 32'(1));
        chk("t1_data", 32'(tx_data), 32'h41);
        chk("t1_grant", 32'(grant_id), 32'(1));
        run_idle(100);
        chk_grants("t1", '{1});

        // simultaneous requests
        do_reset();
        btn_data = {8'h33, 8'h32, 8'h31, 8'h30};
        tx_len = 4;
        step(4'b1111, 1'b0);
        run_idle(200);
        chk_grants("t2", '{0, 1, 2, 3});
        for (int i = 0; i < 4 && i < dq.size(); i++) chk("t2_byte", 32'(dq[i]), 32'h30 + 32'(i));

        // fairness after grant 2
        do_reset();
        step(4'b0100, 1'b0);
        run_idle(100);
        step(4'b1010, 1'b0);
        run_idle(100);
        chk_grants("t3", '{2, 3, 1});

        // overrun while busy, then re-request on the grant cycle
        do_reset();
        tx_len = 12;
        step(4'b0100, 1'b0);
        for (int i = 0; i < 4; i++) step('0, 1'b0);
        step(4'b0001, 1'b0);
        step('0, 1'b0);
        step(4'b0001, 1'b0);
        chk("t4_overrun", 32'(overrun), 32'(4'b0001));
        n = 0;
        while (!(!m_active && m_pend != '0) && n < 100) begin
            step('0, 1'b0);
            n++;
        end
        step(4'b0001, 1'b0);
        chk("t4_regrant_pending", 32'(pending[0]), 32'(1));
        chk("t4_regrant_overrun", 32'(overrun), 32'(4'b0001));
        run_idle(100);
        chk_grants("t4", '{2, 0, 0});

        // ack timeout, then next request still served
        do_reset();
        tx_dead = 1'b1;
        step(4'b0110, 1'b0);
        n = 0;
        while (tx_start !== 1'b1 && n < 10) begin
            step('0, 1'b0);
            n++;
        end
        chk("t5_start_seen", 32'(tx_start), 32'(1));
        s = cyc;
        n = 0;
        while (ack_err !== 1'b1 && n < 40) begin
            step('0, 1'b0);
            n++;
        end
        chk("t5_ack_err", 32'(ack_err), 32'(1));
        chk("t5_ack_latency", 32'(cyc - s), 32'(ACK_TIMEOUT + 1));
        tx_dead = 1'b0;
        tx_len = 3;
        run_idle(100);
        chk_grants("t5", '{1, 2});
        chk("t5_ack_sticky", 32'(ack_err), 32'(1));

        // reset during WAIT_DONE with two pending
        do_reset();
        tx_len = 20;
        step(4'b0010, 1'b0);
        for (int i = 0; i < 6; i++) step('0, 1'b0);
        step(4'b1100, 1'b0);
        step('0, 1'b0);
        chk("t6_pending_before", 32'(pending), 32'(4'b1100));
        step(4'b1000, 1'b1);
        chk("t6_rst_outputs", 32'({tx_start, tx_data, grant_id, pending, overrun, ack_err, ctrl_busy}), 32'(0));
        gq.delete();
        tx_len = 4;
        step('0, 1'b0);
        step(4'b1001, 1'b0);
        run_idle(100);
        chk_grants("t6", '{0, 3});

        // random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [NUM_BTN-1:0] p;
            for (int i = 0; i < NUM_BTN; i++) begin
                p[i] = ($urandom_range(0, 5) == 0);
                btn_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            tx_len  = int'($urandom_range(1, 12));
            tx_dead = ($urandom_range(0, 9) == 0);
            step(p, $urandom_range(0, 399) == 0);
        end
        tx_dead = 1'b0;
        run_idle(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_button_arbiter.md
# uart_tx_button_arbiter

Round-robin scheduler that shares one UART transmitter between several debounced push-buttons. Each button's debouncer delivers a one-cycle pulse. The block latches the pulse as a pending request and arbitrates fairly among pending requests. For each grant it loads that button's byte into the transmitter and issues a one-cycle start strobe. It then waits for the transmitter's busy handshake to complete before granting the next request. It sits between the debounce stage and the UART TX core.

## Interface
- NUM_BTN, 4: number of requesting buttons (≥2)
- DATA_W, 8: byte width per button
- ACK_TIMEOUT, 16: cycles to wait for tx_busy to rise after tx_start before abandoning (≥2)
- ID_W, $clog2(NUM_BTN): width of grant_id (derived)

- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- btn_pulse  in  NUM_BTN  one-cycle request pulses from debouncers, one bit per button
- btn_data  in  NUM_BTN*DATA_W  byte for button i at bits [i*DATA_W +: DATA_W]
- tx_busy  in  1  UART TX busy flag
- tx_start  out  1  one-cycle start strobe to UART TX
- tx_data  out  DATA_W  byte presented to UART TX; stable from tx_start until return to IDLE
- grant_id  out  ID_W  index of the current or most recent grant
- pending  out  NUM_BTN  outstanding requests
- overrun  out  NUM_BTN  sticky: a pulse arrived while that button was already pending
- ack_err  out  1  sticky: a transmit was abandoned on timeout
- ctrl_busy  out  1  high whenever state ≠ IDLE

## Operation
- Reset values: all outputs 0, state IDLE, timeout counter 0, last_grant = NUM_BTN-1 (button 0 has first priority).
- Request capture, every cycle, for each i:
  - btn_pulse[i] with pending[i]=0 → pending[i] set next cycle.
  - btn_pulse[i] with pending[i]=1 and no clear this cycle → overrun[i] set; pending unchanged.
  - Clear and pulse in the same cycle → pending[i] stays 1; no overrun.
- Arbitration: search starts at (last_grant+1) mod NUM_BTN, ascending with wrap. The first pending index wins.
- FSM:
  - IDLE: if pending≠0, latch the winner into grant_id and last_grant. Load tx_data from btn_data for the winner (sampled this cycle), clear its pending bit, and go to START. Otherwise stay.
  - START: tx_start=1 for this cycle only. Reset the timeout counter and go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise increment the counter; when it reaches ACK_TIMEOUT, set ack_err and go to IDLE.
  - WAIT_DONE: stay while tx_busy=1. When tx_busy=0, go to IDLE. No timeout in this state.
- tx_start and ctrl_busy are registered, derived from next-state.
- Overrun and ack_err clear only on rst.

## Timing
- Pulse high in cycle 0 → pending bit high in cycle 1 → tx_start high in cycle 2 (IDLE at the start of cycle 1 with no other work).
- tx_start is high for exactly one cycle per grant.
- Back-to-back grants: after tx_busy falls in cycle k, the FSM is IDLE in cycle k+1 and the next tx_start is high in cycle k+2. Minimum gap is 2 idle cycles.
- Timeout: with tx_busy held low, ack_err rises ACK_TIMEOUT+1 cycles after the tx_start cycle and the FSM returns to IDLE.
- Reset asserted mid-transaction: on the next edge, state IDLE, all pending and sticky flags cleared, tx_start=0. Pulses coinciding with rst are dropped.

## Test plan
- Single request (NUM_BTN=4, btn_data[1]=8'h41): pulse btn 1 in cycle 0, model TX busy for 10 cycles → tx_start in cycle 2, tx_data=8'h41, grant_id=1, pending=0 afterwards.
- Simultaneous requests: pulse all 4 in one cycle with bytes 8'h30..8'h33 → four transmissions in order 0,1,2,3, each tx_start one cycle wide, tx_data matching.
- Fairness: after grant 2 completes, pulse buttons 1 and 3 together → grant 3 first, then 1.
- Overrun: pulse btn 0 twice while the TX is busy with btn 2 → overrun=4'b0001, only one btn-0 transmission. Also pulse btn 0 in the same cycle its request is granted → pending[0] stays 1, no overrun, second transmission follows.
- Timeout: hold tx_busy=0 → ack_err=1 exactly ACK_TIMEOUT+1 cycles after tx_start; next pending request is still served.
- Reset mid-transfer: assert rst in WAIT_DONE with 2 pending → next cycle all outputs 0, state IDLE; a later pulse on btn 0 is granted first.
